instr_encoder_loader: RTL and testbench
=======================================

Name: instr_encoder_loader

Overview:
- Inverse of the control-unit decode path: accepts abstract instruction requests (operation, register numbers, immediate) over a valid/ready handshake and encodes each into a 32-bit MIPS32 word.
- Buffers encoded words in a small FIFO and streams them into instruction memory at consecutive word addresses.
- Used by the test/boot infrastructure to load programs into the MIPS32 SoC instruction memory.

Parameters:
- ADDR_W, 10, instruction-memory word-address width.
- FIFO_DEPTH, 4, encoded-word buffer depth; must be a power of two, ≥2.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-low.
- start  in  1  pulse: load base_addr, clear error flags, enter LOAD.
- finish  in  1  pulse: stop accepting requests, drain the FIFO.
- base_addr  in  ADDR_W  first word address written.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted this cycle when high with req_valid.
- req_op  in  5  operation code (ENC_* enum, below).
- req_rs, req_rt, req_rd  in  5 each  register fields.
- req_imm  in  26  immediate; bits [15:0] are used for I-type, bits [25:0] for J.
- im_wr_en  out  1  memory write strobe.
- im_ready  in  1  memory accepts the write this cycle.
- im_addr  out  ADDR_W  write word address.
- im_wdata  out  32  encoded instruction.
- busy  out  1  state is not IDLE.
- done  out  1  one-cycle pulse when the drain completes.
- words_written  out  ADDR_W+1  count of writes since start.
- err_inv_op  out  1  sticky: an invalid req_op was accepted.
- err_wrap  out  1  sticky: the address wrapped past 2^ADDR_W−1.

Behaviour:
- Reset (rst=0 at a clk edge): state IDLE, FIFO empty, im_addr=0, all outputs 0, req_ready=0.
- States:
  - IDLE: waits for start. start → LOAD, with im_addr=base_addr, words_written=0, error flags cleared.
  - LOAD: req_ready = !fifo_full (not pop-aware). finish → DRAIN.
  - DRAIN: req_ready=0. When the FIFO is empty and no write is in flight → DONE.
  - DONE: done=1 for one cycle → IDLE.
- start outside IDLE is ignored. finish outside LOAD is ignored.
- If start and finish are both high in IDLE, start wins and finish is ignored.
- Accept: req_valid && req_ready. The encoding is computed combinationally and pushed into the FIFO the same cycle. The earliest im_wr_en is the next cycle (latency 1).
- Write side:
  - im_wr_en = FIFO not empty; im_wdata = FIFO head.
  - On im_wr_en && im_ready: pop the head, im_addr+1, words_written+1.
  - im_addr wraps from 2^ADDR_W−1 to 0 and sets err_wrap.
  - im_wdata and im_addr are held stable while im_wr_en && !im_ready.
- A push and a pop in the same cycle are both honoured.
- Invalid op (req_op 22..31): the request is accepted but nothing is pushed, and err_inv_op is set.
- Encoding rules:
  - R-type: {6'h00, rs, rt, rd, 5'd0, func}.
  - I-type: {opc, rs, rt, imm[15:0]}. LUI forces the rs field to 0.
  - J: {6'h02, imm[25:0]}.
  - Unused register fields are driven 0.
- ENC_* enum and the resulting opcode/func:
  - 0 ADD (func 0x20), 1 ADDU (0x21), 2 SUB (0x22), 3 SUBU (0x23), 4 AND (0x24), 5 OR (0x25), 6 XOR (0x26), 7 SLT (0x2A), 8 SLTU (0x2B).
  - 9 ADDI (opc 0x08), 10 ADDIU (0x09), 11 ANDI (0x0C), 12 ORI (0x0D), 13 XORI (0x0E), 14 LUI (0x0F), 15 SLTI (0x0A), 16 SLTIU (0x0B).
  - 17 LW (0x23), 18 SW (0x2B), 19 BEQ (0x04), 20 BNE (0x05), 21 J (0x02).
- Reset asserted mid-operation: FIFO contents are discarded, no further writes occur, and the block returns to IDLE in the same edge.

Decomposition:
- Opcode and func constants come from the existing mips32_opcodes.vh.
- ENC_* request codes and the state encodings go in a new shared header, instr_encoder_defines.vh.
- One sub-module: instr_fifo (synchronous FIFO with push, pop, full, empty and head outputs), parameterized by width and depth.
- The encoder is a combinational function inside the top module.

Test Plan:
- start with base_addr=0x010, then ADD rs=1 rt=2 rd=3 → write 0x00221820 at address 0x010; after finish, done pulses and words_written=1.
- ADDI rt=8 rs=0 imm=0x0005, LW rt=9 rs=29 imm=0x0004, LUI rt=1 rs=7 imm=0x1234, J imm=0x0000010 → writes 0x20080005, 0x8FA90004, 0x3C011234, 0x08000010 to consecutive addresses.
- Hold im_ready=0 while pushing 5 valid requests with FIFO_DEPTH=4 → req_ready drops after 4 accepts and im_wdata/im_addr stay stable. Release im_ready → all 5 words are written in order with no loss.
- req_op=25 between two valid ops → err_inv_op=1, only 2 writes, and the addresses stay contiguous.
- ADDR_W=4, base_addr=0xF, two requests → writes at 0xF then 0x0, err_wrap=1. A following start clears it.
- Assert rst=0 while 3 words are buffered with im_ready=0 → next cycle im_wr_en=0, busy=0, FIFO empty. After release, start works normally.

Source files
------------

// File: rtl/instr_encoder_loader_pkg.sv
// -----------------------------------------------------------------------------
// instr_encoder_loader_pkg
// Shared definitions for the instruction encoder/loader:
//   - MIPS32 primary opcodes and R-type function codes
//   - ENC_* request codes accepted on req_op
//   - loader FSM state encoding
//   - opcode/func lookup helpers used by the encoder
// -----------------------------------------------------------------------------
package instr_encoder_loader_pkg;

  // MIPS32 primary opcodes
  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_J     = 6'h02;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_BNE   = 6'h05;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_ADDIU = 6'h09;
  localparam logic [5:0] OPC_SLTI  = 6'h0A;
  localparam logic [5:0] OPC_SLTIU = 6'h0B;
  localparam logic [5:0] OPC_ANDI  = 6'h0C;
  localparam logic [5:0] OPC_ORI   = 6'h0D;
  localparam logic [5:0] OPC_XORI  = 6'h0E;
  localparam logic [5:0] OPC_LUI   = 6'h0F;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2B;

  // R-type function codes
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  // Request codes; R-type ops occupy 0..8, I-type 9..20, J is 21, 22..31 invalid
  typedef enum logic [4:0] {
    ENC_ADD   = 5'd0,  ENC_ADDU  = 5'd1,  ENC_SUB   = 5'd2,  ENC_SUBU  = 5'd3,
    ENC_AND   = 5'd4,  ENC_OR    = 5'd5,  ENC_XOR   = 5'd6,  ENC_SLT   = 5'd7,
    ENC_SLTU  = 5'd8,  ENC_ADDI  = 5'd9,  ENC_ADDIU = 5'd10, ENC_ANDI  = 5'd11,
    ENC_ORI   = 5'd12, ENC_XORI  = 5'd13, ENC_LUI   = 5'd14, ENC_SLTI  = 5'd15,
    ENC_SLTIU = 5'd16, ENC_LW    = 5'd17, ENC_SW    = 5'd18, ENC_BEQ   = 5'd19,
    ENC_BNE   = 5'd20, ENC_J     = 5'd21
  } enc_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic logic [5:0] func_of(input logic [4:0] op);
    logic [5:0] fn;
    fn = 6'h00;
    case (op)
      ENC_ADD:  fn = FN_ADD;
      ENC_ADDU: fn = FN_ADDU;
      ENC_SUB:  fn = FN_SUB;
      ENC_SUBU: fn = FN_SUBU;
      ENC_AND:  fn = FN_AND;
      ENC_OR:   fn = FN_OR;
      ENC_XOR:  fn = FN_XOR;
      ENC_SLT:  fn = FN_SLT;
      ENC_SLTU: fn = FN_SLTU;
      default:  fn = 6'h00;
    endcase
    return fn;
  endfunction

  function automatic logic [5:0] opc_of(input logic [4:0] op);
    logic [5:0] opc;
    opc = OPC_RTYPE;
    case (op)
      ENC_ADDI:  opc = OPC_ADDI;
      ENC_ADDIU: opc = OPC_ADDIU;
      ENC_ANDI:  opc = OPC_ANDI;
      ENC_ORI:   opc = OPC_ORI;
      ENC_XORI:  opc = OPC_XORI;
      ENC_LUI:   opc = OPC_LUI;
      ENC_SLTI:  opc = OPC_SLTI;
      ENC_SLTIU: opc = OPC_SLTIU;
      ENC_LW:    opc = OPC_LW;
      ENC_SW:    opc = OPC_SW;
      ENC_BEQ:   opc = OPC_BEQ;
      ENC_BNE:   opc = OPC_BNE;
      ENC_J:     opc = OPC_J;
      default:   opc = OPC_RTYPE;
    endcase
    return opc;
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// -----------------------------------------------------------------------------
// instr_fifo
// Synchronous FIFO for encoded instruction words. Push and pop in the same
// cycle are both honoured. Push while full and pop while empty are dropped.
// DEPTH must be a power of two (pointers wrap naturally).
// Ports:
//   clk, rst    clock, synchronous active-low reset (empties the FIFO)
//   push, din   write request and data
//   pop         remove the head entry
//   full, empty occupancy flags
//   head        oldest entry (undefined content while empty)
// -----------------------------------------------------------------------------
module instr_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push, do_pop;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// -----------------------------------------------------------------------------
// instr_encoder_loader
// Encodes abstract instruction requests into MIPS32 words, buffers them and
// streams them into instruction memory at consecutive word addresses.
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | accepting requests, writing buffered words
// DRAIN | no new requests, flushing the FIFO
// DONE  | one-cycle completion pulse
//
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   start, finish, base_addr session control
//   req_*                    request handshake and fields
//   im_wr_en/im_ready/im_addr/im_wdata  instruction-memory write port
//   busy, done, words_written, err_inv_op, err_wrap  status
// -----------------------------------------------------------------------------
module instr_encoder_loader
  import instr_encoder_loader_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              finish,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [4:0]        req_op,
  input  logic [4:0]        req_rs,
  input  logic [4:0]        req_rt,
  input  logic [4:0]        req_rd,
  input  logic [25:0]       req_imm,
  output logic              im_wr_en,
  input  logic              im_ready,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   words_written,
  output logic              err_inv_op,
  output logic              err_wrap
);

  function automatic logic [31:0] encode(input logic [4:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [4:0] rd,
                                         input logic [25:0] imm);
    logic [31:0] w;
    if (op <= ENC_SLTU)
      w = {OPC_RTYPE, rs, rt, rd, 5'd0, func_of(op)};
    else if (op == ENC_J)
      w = {OPC_J, imm};
    else if (op == ENC_LUI)
      w = {opc_of(op), 5'd0, rt, imm[15:0]};
    else
      w = {opc_of(op), rs, rt, imm[15:0]};
    return w;
  endfunction

  state_e      state;
  logic        fifo_full, fifo_empty;
  logic [31:0] fifo_head;
  logic        accept, op_valid, push, pop;

  assign op_valid  = (req_op <= ENC_J);
  assign req_ready = (state == ST_LOAD) && !fifo_full;
  assign accept    = req_valid && req_ready;
  assign push      = accept && op_valid;
  assign im_wr_en  = !fifo_empty;
  assign pop       = im_wr_en && im_ready;
  // Masked so the data bus reads 0 rather than stale storage when idle.
  assign im_wdata  = fifo_empty ? 32'h0 : fifo_head;
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);

  instr_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (encode(req_op, req_rs, req_rt, req_rd, req_imm)),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= ST_IDLE;
      im_addr       <= '0;
      words_written <= '0;
      err_inv_op    <= 1'b0;
      err_wrap      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          state         <= ST_LOAD;
          im_addr       <= base_addr;
          words_written <= '0;
          err_inv_op    <= 1'b0;
          err_wrap      <= 1'b0;
        end
        ST_LOAD:  if (finish) state <= ST_DRAIN;
        // Empty FIFO means no write is pending either.
        ST_DRAIN: if (fifo_empty) state <= ST_DONE;
        ST_DONE:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
      // The FIFO is always empty in IDLE, so this never collides with start.
      if (pop) begin
        im_addr       <= im_addr + 1'b1;
        words_written <= words_written + 1'b1;
        if (im_addr == '1) err_wrap <= 1'b1;
      end
      if (accept && !op_valid) err_inv_op <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
module tb_instr_encoder_loader;

  localparam int ADDR_W = 10;
  localparam int AMAX   = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst, start, finish, req_valid, im_ready;
  logic [ADDR_W-1:0] base_addr;
  logic [4:0]        req_op, req_rs, req_rt, req_rd;
  logic [25:0]       req_imm;
  logic              req_ready, im_wr_en, busy, done, err_inv_op, err_wrap;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;
  logic [ADDR_W:0]   words_written;

  instr_encoder_loader #(.ADDR_W(ADDR_W), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .finish(finish), .base_addr(base_addr),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_rs(req_rs),
    .req_rt(req_rt), .req_rd(req_rd), .req_imm(req_imm), .im_wr_en(im_wr_en),
    .im_ready(im_ready), .im_addr(im_addr), .im_wdata(im_wdata), .busy(busy),
    .done(done), .words_written(words_written), .err_inv_op(err_inv_op),
    .err_wrap(err_wrap)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference encoder built from the opcode/func tables with plain arithmetic.
  function automatic logic [31:0] ref_word(input int op, input int rs, input int rt,
                                           input int rd, input longint unsigned imm);
    longint unsigned func_tab[9] = '{32, 33, 34, 35, 36, 37, 38, 42, 43};
    longint unsigned opc_tab[12] = '{8, 9, 12, 13, 14, 15, 10, 11, 35, 43, 4, 5};
    longint unsigned w;
    if (op <= 8)
      w = rs * 2**21 + rt * 2**16 + rd * 2**11 + func_tab[op];
    else if (op <= 20)
      w = opc_tab[op-9] * 2**26 + ((op == 14) ? 0 : rs) * 2**21 + rt * 2**16 + (imm % 65536);
    else
      w = 2 * 2**26 + (imm % 2**26);
    return w[31:0];
  endfunction

  // Model state
  logic [31:0] mdl_q[$];
  int          exp_addr = 0;
  int          mdl_written = 0;
  bit          mdl_inv = 0, mdl_wrap = 0;
  bit          log_en = 0;
  logic [31:0] log_d[$];
  int          log_a[$];
  bit          rand_rdy = 0;

  // Outputs and inputs are stable mid-cycle: predict what the coming edge does.
  always @(negedge clk) begin
    if (!rst) begin
      mdl_q.delete();
    end else begin
      if (im_wr_en && im_ready) begin
        if (mdl_q.size() == 0) begin
          chk("unexpected_write", im_wdata, 32'hDEAD_BEEF);
        end else begin
          chk("wr_data", im_wdata, mdl_q[0]);
          chk("wr_addr", 32'(im_addr), 32'(exp_addr));
          if (log_en) begin
            log_d.push_back(im_wdata);
            log_a.push_back(int'(im_addr));
          end
          void'(mdl_q.pop_front());
          if (exp_addr == AMAX - 1) mdl_wrap = 1;
          exp_addr = (exp_addr + 1) % AMAX;
          mdl_written++;
        end
      end
      if (req_valid && req_ready) begin
        if (req_op <= 21) mdl_q.push_back(ref_word(req_op, req_rs, req_rt, req_rd, req_imm));
        else mdl_inv = 1;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_rdy) im_ready = 1'($urandom_range(0, 1));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int base, input logic with_finish);
    exp_addr = base; mdl_written = 0; mdl_inv = 0; mdl_wrap = 0;
    base_addr = ADDR_W'(base); start = 1'b1; finish = with_finish;
    step();
    start = 1'b0; finish = 1'b0;
  endtask

  task automatic send(input int op, input int rs, input int rt, input int rd, input int imm);
    int n;
    req_op = 5'(op); req_rs = 5'(rs); req_rt = 5'(rt); req_rd = 5'(rd); req_imm = 26'(imm);
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 100) begin step(); n++; end
    if (n >= 100) chk("send_timeout", 32'(req_ready), 32'd1);
    step();
    req_valid = 1'b0;
  endtask

  task automatic finish_and_wait();
    int n;
    bit seen;
    finish = 1'b1; step(); finish = 1'b0;
    seen = 0; n = 0;
    while (!seen && n < 300) begin
      if (done) seen = 1;
      else begin step(); n++; end
    end
    chk("done_seen", 32'(seen), 32'd1);
    step();
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("idle_after_done", 32'(busy), 32'd0);
    chk("model_drained", 32'(mdl_q.size()), 32'd0);
  endtask

  typedef struct {
    int op, rs, rt, rd, imm;
    logic [31:0] word;
  } vec_t;

  vec_t vecs[11];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{0,  1,  2,  3,  0,          32'h00221820};
    vecs[1]  = '{9,  0,  8,  0,  'h5,        32'h20080005};
    vecs[2]  = '{17, 29, 9,  17, 'h4,        32'h8FA90004};
    vecs[3]  = '{14, 7,  1,  0,  'h1234,     32'h3C011234};
    vecs[4]  = '{21, 0,  0,  0,  'h10,       32'h08000010};
    vecs[5]  = '{2,  4,  5,  6,  'h2AAAAAA,  32'h00853022};
    vecs[6]  = '{8,  31, 31, 31, 0,          32'h03FFF82B};
    vecs[7]  = '{18, 2,  3,  0,  'hFFFC,     32'hAC43FFFC};
    vecs[8]  = '{20, 1,  0,  0,  'hFFFF,     32'h1420FFFF};
    vecs[9]  = '{12, 3,  4,  0,  'h3FFABCD,  32'h3464ABCD};
    vecs[10] = '{21, 5,  6,  7,  'h3FFFFFF,  32'h0BFFFFFF};

    rst = 1'b0; start = 1'b0; finish = 1'b0; base_addr = '0; req_valid = 1'b0;
    req_op = '0; req_rs = '0; req_rt = '0; req_rd = '0; req_imm = '0; im_ready = 1'b0;
    repeat (3) step();
    chk("rst_wr_en", 32'(im_wr_en), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_addr", 32'(im_addr), 0);
    chk("rst_ww", 32'(words_written), 0);
    chk("rst_errs", {30'd0, err_inv_op, err_wrap}, 0);
    rst = 1'b1;
    step();

    // Table-driven encodings
    im_ready = 1'b1;
    do_start('h010, 1'b0);
    chk("start_busy", 32'(busy), 1);
    chk("start_addr", 32'(im_addr), 'h010);
    chk("start_ready", 32'(req_ready), 1);
    log_en = 1;
    for (int i = 0; i < 11; i++) send(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].imm);
    finish_and_wait();
    log_en = 0;
    chk("tbl_ww", 32'(words_written), 11);
    chk("tbl_count", 32'(log_d.size()), 11);
    for (int i = 0; i < 11 && i < log_d.size(); i++) begin
      chk($sformatf("tbl_word%0d", i), log_d[i], vecs[i].word);
      chk($sformatf("tbl_addr%0d", i), 32'(log_a[i]), 32'('h010 + i));
    end

    // Backpressure: 5 requests against a 4-deep FIFO
    im_ready = 1'b0;
    do_start('h100, 1'b0);
    for (int i = 0; i < 4; i++) send(i, i + 1, i + 2, i + 3, i);
    chk("bp_ready_low", 32'(req_ready), 0);
    req_op = 5'd10; req_rs = 5'd1; req_rt = 5'd2; req_rd = 5'd0; req_imm = 26'h77; req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("bp_hold_ready", 32'(req_ready), 0);
      chk("bp_hold_wr_en", 32'(im_wr_en), 1);
      chk("bp_hold_addr", 32'(im_addr), 'h100);
      chk("bp_hold_data", im_wdata, ref_word(0, 1, 2, 3, 0));
      step();
    end
    im_ready = 1'b1;
    send(10, 1, 2, 0, 'h77);
    finish_and_wait();
    chk("bp_ww", 32'(words_written), 5);

    // Invalid op between two valid ops; start+finish together stays in LOAD
    do_start('h200, 1'b1);
    chk("sf_ready", 32'(req_ready), 1);
    base_addr = 10'h0AB; start = 1'b1; step(); start = 1'b0;
    chk("start_in_load_ignored", 32'(im_addr), 'h200);
    send(0, 1, 2, 3, 0);
    send(25, 1, 2, 3, 0);
    send(12, 3, 4, 0, 'hBEEF);
    finish_and_wait();
    chk("inv_flag", 32'(err_inv_op), 1);
    chk("inv_ww", 32'(words_written), 2);
    chk("inv_addr_end", 32'(im_addr), 'h202);

    // Address wrap, then cleared by the next start
    do_start(AMAX - 1, 1'b0);
    send(1, 4, 5, 6, 0);
    send(13, 7, 8, 0, 'h1111);
    finish_and_wait();
    chk("wrap_flag", 32'(err_wrap), 1);
    chk("wrap_ww", 32'(words_written), 2);
    chk("wrap_addr_end", 32'(im_addr), 1);
    do_start(0, 1'b0);
    chk("wrap_cleared", {30'd0, err_inv_op, err_wrap}, 0);
    finish_and_wait();

    // Reset with words buffered
    im_ready = 1'b0;
    do_start('h050, 1'b0);
    for (int i = 0; i < 3; i++) send(5, i, i, i, 0);
    chk("pre_rst_wr_en", 32'(im_wr_en), 1);
    rst = 1'b0; step(); rst = 1'b1;
    chk("mid_rst_wr_en", 32'(im_wr_en), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_ready", 32'(req_ready), 0);
    step();
    chk("post_rst_wr_en", 32'(im_wr_en), 0);
    im_ready = 1'b1;
    do_start('h060, 1'b0);
    send(19, 1, 2, 0, 'h8);
    send(21, 0, 0, 0, 'h123);
    finish_and_wait();
    chk("post_rst_ww", 32'(words_written), 2);

    // Randomized rounds with random memory back-pressure
    rand_rdy = 1;
    for (int r = 0; r < 6; r++) begin
      int n;
      do_start(int'($urandom_range(0, AMAX - 1)), 1'b0);
      n = int'($urandom_range(8, 20));
      for (int k = 0; k < n; k++) begin
        send(int'($urandom_range(0, 24)), int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
             int'($urandom_range(0, 31)), int'($urandom_range(0, (1 << 26) - 1)));
        repeat ($urandom_range(0, 2)) step();
      end
      finish_and_wait();
      chk("rnd_ww", 32'(words_written), 32'(mdl_written));
      chk("rnd_inv", 32'(err_inv_op), 32'(mdl_inv));
      chk("rnd_wrap", 32'(err_wrap), 32'(mdl_wrap));
    end
    rand_rdy = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
